// File: rtl/a2d_pkg.sv
// Shared A2D definitions: sequencer state encoding, SPI command width and the
// channel numbers of the three analog inputs.
package a2d_pkg;

   localparam int A2D_CMD_W = 16;
   localparam int A2D_RES_W = 12;

   localparam logic [2:0] CH_LFT  = 3'd0;
   localparam logic [2:0] CH_RGHT = 3'd4;
   localparam logic [2:0] CH_BATT = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT_CMD,
      GAP,
      READ,
      WAIT_READ,
      STORE,
      DONE
   } a2d_state_t;

   // The A2D command word: channel select in [13:11], everything else zero.
   function automatic logic [A2D_CMD_W-1:0] a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master for the A2D: SCLK idles high, MOSI changes on SCLK falls,
// MISO is sampled the clk before each SCLK rise.
module spi_mstr16
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [A2D_CMD_W-1:0] cmd,
   input  logic                 MISO,
   output logic                 done,
   output logic [A2D_CMD_W-1:0] rd_data,
   output logic                 SS_n,
   output logic                 SCLK,
   output logic                 MOSI
);

   localparam logic [SCLK_DIV_W-1:0] CNT_LOAD = {1'b1, 1'b0, {(SCLK_DIV_W-2){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] CNT_SMPL = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] CNT_FALL = {SCLK_DIV_W{1'b1}};
   localparam logic [SCLK_DIV_W-1:0] CNT_ONE  = {{(SCLK_DIV_W-1){1'b0}}, 1'b1};

   logic [SCLK_DIV_W-1:0] cnt;
   logic [4:0]            fall_cnt;
   logic [A2D_CMD_W-1:0]  shft;
   logic                  last;

   // The first fall is the front porch; after the 16th fall the counter runs
   // on with SCLK high until it would wrap again, which ends the frame.
   assign last    = !SS_n && (cnt == CNT_FALL) && (fall_cnt == 5'd16);
   assign SCLK    = SS_n | cnt[SCLK_DIV_W-1];
   assign rd_data = shft;

   // One register shifts commands out and results in, so no separate rx path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         fall_cnt <= '0;
         shft     <= '0;
      end else begin
         done <= 1'b0;
         if (SS_n) begin
            if (start) begin
               SS_n     <= 1'b0;
               cnt      <= CNT_LOAD;
               fall_cnt <= '0;
               shft     <= cmd;
            end
         end else if (last) begin
            SS_n <= 1'b1;
            done <= 1'b1;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_FALL) begin
               MOSI     <= shft[A2D_CMD_W-1];
               shft     <= {shft[A2D_CMD_W-2:0], 1'b0};
               fall_cnt <= fall_cnt + 5'd1;
            end else if (cnt == CNT_SMPL) begin
               shft[0] <= MISO;
            end
         end
      end
   end

endmodule

// File: rtl/a2d_round_robin_seq.sv
// Round-robin A2D scheduler: each nxt request converts the left load cell,
// right load cell and battery, two SPI frames per channel.
module a2d_round_robin_seq
   import a2d_pkg::*;
#(
   parameter int         SCLK_DIV_W = 5,
   parameter logic [2:0] CH_LFT     = a2d_pkg::CH_LFT,
   parameter logic [2:0] CH_RGHT    = a2d_pkg::CH_RGHT,
   parameter logic [2:0] CH_BATT    = a2d_pkg::CH_BATT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 nxt,
   input  logic                 MISO,
   output logic                 SS_n,
   output logic                 SCLK,
   output logic                 MOSI,
   output logic [A2D_RES_W-1:0] lft_ld,
   output logic [A2D_RES_W-1:0] rght_ld,
   output logic [A2D_RES_W-1:0] batt,
   output logic                 rnd_done
);

   a2d_state_t           state, state_nxt;
   logic                 pending;
   logic [1:0]           ch_idx;
   logic [2:0]           cur_ch;
   logic                 spi_start;
   logic                 spi_done;
   logic [A2D_CMD_W-1:0] spi_rd;
   logic [A2D_RES_W-1:0] res;

   assign res      = spi_rd[A2D_RES_W-1:0];
   assign rnd_done = (state == DONE);

   always_comb begin
      cur_ch = CH_BATT;
      case (ch_idx)
         2'd0:    cur_ch = CH_LFT;
         2'd1:    cur_ch = CH_RGHT;
         default: cur_ch = CH_BATT;
      endcase
   end

   spi_mstr16 #(
      .SCLK_DIV_W(SCLK_DIV_W)
   ) u_spi (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (spi_start),
      .cmd    (a2d_cmd(cur_ch)),
      .MISO   (MISO),
      .done   (spi_done),
      .rd_data(spi_rd),
      .SS_n   (SS_n),
      .SCLK   (SCLK),
      .MOSI   (MOSI)
   );

   always_comb begin
      state_nxt = state;
      spi_start = 1'b0;
      case (state)
         IDLE:      if (nxt || pending) state_nxt = CMD;
         CMD: begin
            spi_start = 1'b1;
            state_nxt = WAIT_CMD;
         end
         WAIT_CMD:  if (spi_done) state_nxt = GAP;
         GAP:       state_nxt = READ;
         READ: begin
            spi_start = 1'b1;
            state_nxt = WAIT_READ;
         end
         WAIT_READ: if (spi_done) state_nxt = STORE;
         STORE:     state_nxt = (ch_idx < 2'd2) ? CMD : DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Any request seen while a round is in flight (DONE included) is remembered
   // once and consumed by the following IDLE clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= 1'b0;
         ch_idx  <= 2'd0;
         lft_ld  <= '0;
         rght_ld <= '0;
         batt    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            pending <= 1'b0;
         else if (nxt)
            pending <= 1'b1;
         if (state == IDLE)
            ch_idx <= 2'd0;
         else if (state == STORE && ch_idx < 2'd2)
            ch_idx <= ch_idx + 2'd1;
         if (state == STORE) begin
            case (ch_idx)
               2'd0:    lft_ld  <= res;
               2'd1:    rght_ld <= res;
               default: batt    <= res;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_a2d_round_robin_seq.sv
// Self-checking bench for a2d_round_robin_seq with a behavioural A2D slave that
// answers each frame with the channel named by the previous frame's command.
module tb_a2d_round_robin_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nxt = 1'b0;
   logic        MISO;
   logic        SS_n, SCLK, MOSI, rnd_done;
   logic [11:0] lft_ld, rght_ld, batt;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   a2d_round_robin_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .nxt     (nxt),
      .MISO    (MISO),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .lft_ld  (lft_ld),
      .rght_ld (rght_ld),
      .batt    (batt),
      .rnd_done(rnd_done)
   );

   // A2D slave model
   logic [15:0] lft_word = 16'h0, rght_word = 16'h0, batt_word = 16'h0;
   logic [15:0] tx_word = 16'h0, rx_word = 16'h0;
   logic [2:0]  prev_ch = 3'd0;
   int          rises = 16;
   logic [15:0] cmd_q[$];

   function automatic logic [15:0] resp(input logic [2:0] ch);
      case (ch)
         3'd0:    return lft_word;
         3'd4:    return rght_word;
         3'd5:    return batt_word;
         default: return 16'hDEAD;
      endcase
   endfunction

   always @(negedge SS_n) begin
      rises   = 0;
      rx_word = 16'h0;
      tx_word = resp(prev_ch);
   end

   always @(posedge SCLK) begin
      if (!SS_n && rises < 16) begin
         rx_word = {rx_word[14:0], MOSI};
         rises++;
      end
   end

   always @(posedge SS_n) begin
      cmd_q.push_back(rx_word);
      prev_ch = rx_word[13:11];
   end

   assign MISO = (rises < 16) ? tx_word[15-rises] : 1'b0;

   // Bus monitor: frame lengths, SCLK falls per frame, high gaps, rnd_done
   int   low_len = 0, high_len = 0, fall_cnt = 0, done_cnt = 0;
   logic prev_sclk = 1'b1;
   int   low_q[$], gap_q[$], fall_q[$];

   always @(negedge clk) begin
      if (rnd_done) done_cnt++;
      if (!SS_n) begin
         if (low_len == 0) begin
            gap_q.push_back(high_len);
            high_len = 0;
         end
         low_len++;
         if (prev_sclk && !SCLK) fall_cnt++;
      end else begin
         if (low_len > 0) begin
            low_q.push_back(low_len);
            fall_q.push_back(fall_cnt);
         end
         low_len  = 0;
         fall_cnt = 0;
         high_len++;
      end
      prev_sclk = SCLK;
   end

   typedef struct {
      logic [15:0] lw, rw, bw;
      logic [11:0] el, er, eb;
   } vec_t;

   vec_t        vecs[4];
   logic [15:0] exp_cmd[6];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      low_q.delete();
      gap_q.delete();
      fall_q.delete();
      cmd_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_nxt();
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rnd_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      bit ok;
      lft_word  = v.lw;
      rght_word = v.rw;
      batt_word = v.bw;
      pulse_nxt();
      wait_done(4000, ok);
      check_output("round_done", 32'(ok), 32'd1);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_results(input string tag, input vec_t v);
      check_output({tag, "_lft"}, 32'(lft_ld), 32'(v.el));
      check_output({tag, "_rght"}, 32'(rght_ld), 32'(v.er));
      check_output({tag, "_batt"}, 32'(batt), 32'(v.eb));
   endtask

   // Frames of one round: six commands, 521-clk windows, 16 SCLK falls, and
   // 3 high clks between frames (done clk, GAP/STORE, CMD/READ start clk).
   task automatic check_round(input string tag);
      check_output({tag, "_frames"}, 32'(low_q.size()), 32'd6);
      check_output({tag, "_cmds"}, 32'(cmd_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < low_q.size() && i < cmd_q.size(); i++) begin
         check_output($sformatf("%s_cmd%0d", tag, i), 32'(cmd_q[i]), 32'(exp_cmd[i]));
         check_output($sformatf("%s_sslow%0d", tag, i), 32'(low_q[i]), 32'd521);
         check_output($sformatf("%s_falls%0d", tag, i), 32'(fall_q[i]), 32'd16);
         if (i > 0 && i < gap_q.size())
            check_output($sformatf("%s_gap%0d", tag, i), 32'(gap_q[i]), 32'd3);
      end
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit ok;
      int k;

      vecs[0] = '{16'h03A5, 16'h05C2, 16'h0A10, 12'h3A5, 12'h5C2, 12'hA10};
      vecs[1] = '{16'h03A5, 16'h05C2, 16'hF123, 12'h3A5, 12'h5C2, 12'h123};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'h8001, 12'hFFF, 12'h000, 12'h001};
      vecs[3] = '{16'h5ABC, 16'hA543, 16'h0FFF, 12'hABC, 12'h543, 12'hFFF};
      exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};

      // Idle after reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (1000) @(negedge clk);
      check_output("idle_ss_n", 32'(SS_n), 32'd1);
      check_output("idle_sclk", 32'(SCLK), 32'd1);
      check_output("idle_mosi", 32'(MOSI), 32'd0);
      check_output("idle_lft", 32'(lft_ld), 32'd0);
      check_output("idle_rght", 32'(rght_ld), 32'd0);
      check_output("idle_batt", 32'(batt), 32'd0);
      check_output("idle_done_cnt", 32'(done_cnt), 32'd0);
      check_output("idle_frames", 32'(low_q.size()), 32'd0);

      // Table-driven rounds
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         apply_stimulus(vecs[i]);
         check_results($sformatf("vec%0d", i), vecs[i]);
         check_round($sformatf("vec%0d", i));
         check_output($sformatf("vec%0d_done_cnt", i), 32'(done_cnt), 32'd1);
      end

      // Three requests during one round coalesce into one more round
      clear_mon();
      lft_word  = vecs[0].lw;
      rght_word = vecs[0].rw;
      batt_word = vecs[0].bw;
      pulse_nxt();
      repeat (100) @(negedge clk);
      pulse_nxt();
      repeat (1500) @(negedge clk);
      pulse_nxt();
      repeat (1000) @(negedge clk);
      pulse_nxt();
      wait_done(4000, ok);
      check_output("coal_first_done", 32'(ok), 32'd1);
      k = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (!SS_n) begin
            k = i;
            break;
         end
      end
      check_output("coal_restart_clks", 32'(k), 32'd3);
      wait_done(4000, ok);
      check_output("coal_second_done", 32'(ok), 32'd1);
      repeat (4000) @(negedge clk);
      check_output("coal_done_cnt", 32'(done_cnt), 32'd2);
      check_output("coal_frames", 32'(low_q.size()), 32'd12);
      check_results("coal", vecs[0]);

      // Request in the DONE clk is kept
      clear_mon();
      lft_word  = vecs[3].lw;
      rght_word = vecs[3].rw;
      batt_word = vecs[3].bw;
      pulse_nxt();
      wait_done(4000, ok);
      check_output("donenxt_first", 32'(ok), 32'd1);
      nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      wait_done(4000, ok);
      check_output("donenxt_second", 32'(ok), 32'd1);
      repeat (4000) @(negedge clk);
      check_output("donenxt_done_cnt", 32'(done_cnt), 32'd2);
      check_results("donenxt", vecs[3]);

      // Reset in the middle of the right-channel read
      clear_mon();
      lft_word  = vecs[0].lw;
      rght_word = vecs[0].rw;
      batt_word = vecs[0].bw;
      pulse_nxt();
      repeat (50) @(negedge clk);
      pulse_nxt();
      k = 0;
      while (gap_q.size() < 4 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      check_output("rst_reached_rght_read", 32'(gap_q.size()), 32'd4);
      repeat (200) @(negedge clk);
      check_output("rst_pre_lft", 32'(lft_ld), 32'h3A5);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_ss_n", 32'(SS_n), 32'd1);
      check_output("rst_sclk", 32'(SCLK), 32'd1);
      check_output("rst_lft", 32'(lft_ld), 32'd0);
      check_output("rst_rght", 32'(rght_ld), 32'd0);
      check_output("rst_batt", 32'(batt), 32'd0);
      check_output("rst_rnd_done", 32'(rnd_done), 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (4000) @(negedge clk);
      check_output("rst_no_done", 32'(done_cnt), 32'd0);
      check_output("rst_no_frames", 32'(gap_q.size()), 32'd0);

      clear_mon();
      apply_stimulus(vecs[2]);
      check_results("post_rst", vecs[2]);
      check_round("post_rst");
      check_output("post_rst_done_cnt", 32'(done_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
